// File: rtl/foo_ctrl_pkg.sv
// Shared types, parameter defaults and the coefficient packing helper
// for the foo_correction control sequencer.
package foo_ctrl_pkg;

  localparam int unsigned P_CH_NUM_DEF   = 4;
  localparam int unsigned P_K_BIT_DEF    = 10;
  localparam int unsigned P_PIPELINE_DEF = 3;

  // Upper bounds the packing helper can handle (channels x coefficient bits).
  localparam int unsigned COEFF_MAX_CH = 16;
  localparam int unsigned COEFF_MAX_K  = 16;
  localparam int unsigned COEFF_FLAT_W = COEFF_MAX_CH * COEFF_MAX_K;
  localparam int unsigned CH_IDX_W     = $clog2(COEFF_MAX_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } foo_seq_state_t;

  typedef logic [COEFF_MAX_K-1:0]  coeff_word_t;
  typedef logic [COEFF_FLAT_W-1:0] coeff_flat_t;

  // Concatenate the first ch_num words (k_bit wide each), channel 0 in the LSBs.
  function automatic coeff_flat_t pack_coeff(input coeff_word_t words [COEFF_MAX_CH],
                                             input int unsigned ch_num,
                                             input int unsigned k_bit);
    coeff_flat_t flat;
    coeff_word_t mask;
    flat = '0;
    mask = coeff_word_t'((32'd1 << k_bit) - 32'd1);
    for (int i = int'(COEFF_MAX_CH) - 1; i >= 0; i--) begin
      if (i < int'(ch_num)) begin
        flat = (flat << k_bit) | coeff_flat_t'(words[CH_IDX_W'(i)] & mask);
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/foo_coeff_sequencer_if.sv
// Config-side write/commit bus of the coefficient sequencer; signal
// directions are named from the sequencer's point of view.
interface foo_coeff_sequencer_if
  import foo_ctrl_pkg::*;
#(
  parameter int unsigned p_ch_num = P_CH_NUM_DEF,
  parameter int unsigned p_k_bit  = P_K_BIT_DEF
);
  localparam int unsigned CH_W  = $clog2(p_ch_num);
  localparam int unsigned VEC_W = p_ch_num * p_k_bit;

  logic                i_WR_VALID;
  logic                o_WR_READY;
  logic [CH_W-1:0]     i_WR_CH;
  logic [p_k_bit-1:0]  i_WR_COEFF;
  logic                i_WR_ENA;
  logic                i_COMMIT_REQ;
  logic                i_FRAME_START;
  logic                o_COMMIT_PEND;
  logic                o_COMMIT_DONE;
  logic [VEC_W-1:0]    o_COEFF_VEC;
  logic [p_ch_num-1:0] o_ENA_VEC;

  modport master (
    output i_WR_VALID, i_WR_CH, i_WR_COEFF, i_WR_ENA, i_COMMIT_REQ, i_FRAME_START,
    input  o_WR_READY, o_COMMIT_PEND, o_COMMIT_DONE, o_COEFF_VEC, o_ENA_VEC
  );

  modport slave (
    input  i_WR_VALID, i_WR_CH, i_WR_COEFF, i_WR_ENA, i_COMMIT_REQ, i_FRAME_START,
    output o_WR_READY, o_COMMIT_PEND, o_COMMIT_DONE, o_COEFF_VEC, o_ENA_VEC
  );

endinterface

// File: rtl/foo_coeff_bank.sv
// Shadow and active coefficient/enable registers. Writes land in the shadow
// bank; a swap copies the whole shadow set into the active registers at once.
module foo_coeff_bank
  import foo_ctrl_pkg::*;
#(
  parameter  int unsigned p_ch_num = P_CH_NUM_DEF,
  parameter  int unsigned p_k_bit  = P_K_BIT_DEF,
  localparam int unsigned CH_W     = $clog2(p_ch_num),
  localparam int unsigned VEC_W    = p_ch_num * p_k_bit
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [p_k_bit-1:0]  i_wr_coeff,
  input  logic                i_wr_ena,
  input  logic                i_swap,
  output logic [VEC_W-1:0]    o_coeff_vec,
  output logic [p_ch_num-1:0] o_ena_vec
);

  logic [p_k_bit-1:0]  r_shadow_coeff [p_ch_num];
  logic [p_ch_num-1:0] r_shadow_ena;
  logic [VEC_W-1:0]    r_active_coeff;
  logic [p_ch_num-1:0] r_active_ena;

  coeff_word_t w_shadow_words [COEFF_MAX_CH];
  logic        w_wr_hit;

  // Out-of-range channels are accepted upstream but must not touch the bank.
  assign w_wr_hit = i_wr_en && ({1'b0, i_wr_ch} < (CH_W + 1)'(p_ch_num));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow_coeff <= '{default: '0};
      r_shadow_ena   <= '0;
    end else if (w_wr_hit) begin
      r_shadow_coeff[i_wr_ch] <= i_wr_coeff;
      r_shadow_ena[i_wr_ch]   <= i_wr_ena;
    end
  end

  for (genvar g = 0; g < COEFF_MAX_CH; g++) begin : g_words
    if (g < p_ch_num) begin : g_used
      assign w_shadow_words[g] = coeff_word_t'(r_shadow_coeff[g]);
    end else begin : g_pad
      assign w_shadow_words[g] = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active_coeff <= '0;
      r_active_ena   <= '0;
    end else if (i_swap) begin
      r_active_coeff <= VEC_W'(pack_coeff(w_shadow_words, p_ch_num, p_k_bit));
      r_active_ena   <= r_shadow_ena;
    end
  end

  assign o_coeff_vec = r_active_coeff;
  assign o_ena_vec   = r_active_ena;

endmodule

// File: rtl/foo_coeff_sequencer.sv
// Commit sequencer: arms on a commit request, waits for a frame boundary,
// drains the datapath pipeline, then swaps the shadow set in atomically.
module foo_coeff_sequencer
  import foo_ctrl_pkg::*;
#(
  parameter int unsigned p_ch_num   = P_CH_NUM_DEF,
  parameter int unsigned p_k_bit    = P_K_BIT_DEF,
  parameter int unsigned p_pipeline = P_PIPELINE_DEF
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  foo_coeff_sequencer_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(p_pipeline + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_pipeline - 1);

  foo_seq_state_t   r_state;
  foo_seq_state_t   w_next_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_wr_ready;
  logic             r_commit_pend;
  logic             r_commit_done;
  logic             w_wr_fire;
  logic             w_swap;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_fire    = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      IDLE: begin
        w_wr_fire = bus.i_WR_VALID && r_wr_ready;
        if (bus.i_COMMIT_REQ) begin
          w_next_state = ARMED;
        end
      end
      ARMED: begin
        if (bus.i_FRAME_START) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == CNT_LAST) begin
          w_next_state = SWAP;
        end
      end
      SWAP: begin
        w_swap       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Held at zero outside DRAIN so every drain starts counting from 0.
  always_ff @(posedge i_CLK) begin
    if (i_RST || (r_state != DRAIN)) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_wr_ready    <= 1'b0;
      r_commit_pend <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_wr_ready    <= (w_next_state == IDLE);
      r_commit_pend <= (w_next_state != IDLE);
      r_commit_done <= w_swap;
    end
  end

  foo_coeff_bank #(
    .p_ch_num (p_ch_num),
    .p_k_bit  (p_k_bit)
  ) u_bank (
    .i_clk       (i_CLK),
    .i_rst       (i_RST),
    .i_wr_en     (w_wr_fire),
    .i_wr_ch     (bus.i_WR_CH),
    .i_wr_coeff  (bus.i_WR_COEFF),
    .i_wr_ena    (bus.i_WR_ENA),
    .i_swap      (w_swap),
    .o_coeff_vec (bus.o_COEFF_VEC),
    .o_ena_vec   (bus.o_ENA_VEC)
  );

  assign bus.o_WR_READY    = r_wr_ready;
  assign bus.o_COMMIT_PEND = r_commit_pend;
  assign bus.o_COMMIT_DONE = r_commit_done;

endmodule
